mem_arbiter: RTL and testbench

Two-requester memory-port arbiter placed between the core datapath and its single memory interface. It shares one request/response memory port between the instruction-fetch requester (IF) and the load/store requester (LS, which carries `sd` stores). It grants one requester at a time, registers the request, and drives it to memory. It then routes the single response back to the owner, with at most one transaction outstanding.

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Bundles the three handshake groups that surround mem_arbiter:
//   - IF requester : if_req_valid/addr/ready, if_resp_valid/data
//   - LS requester : ls_req_valid/addr/wen/wdata/wmask/ready, ls_resp_valid/data
//   - memory port  : mem_req_valid/addr/wen/wdata/wmask/ready,
//                    mem_resp_valid/data
//
// Modports:
//   slave  - the arbiter's view (takes requests, drives the memory port)
//   master - the environment's view (requesters plus memory model)
//
// Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int AW = 64,
   parameter int DW = 64
);
   // Instruction-fetch requester
   logic          if_req_valid;
   logic [AW-1:0] if_req_addr;
   logic          if_req_ready;
   logic          if_resp_valid;
   logic [DW-1:0] if_resp_data;

   // Load/store requester
   logic          ls_req_valid;
   logic [AW-1:0] ls_req_addr;
   logic          ls_req_wen;
   logic [DW-1:0] ls_req_wdata;
   logic [7:0]    ls_req_wmask;
   logic          ls_req_ready;
   logic          ls_resp_valid;
   logic [DW-1:0] ls_resp_data;

   // Shared memory port
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_req_wen;
   logic [DW-1:0] mem_req_wdata;
   logic [7:0]    mem_req_wmask;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_resp_valid, if_resp_data,
      input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
      output ls_req_ready, ls_resp_valid, ls_resp_data,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      input  mem_req_ready, mem_resp_valid, mem_resp_data
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_resp_valid, if_resp_data,
      output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
      input  ls_req_ready, ls_resp_valid, ls_resp_data,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
      output mem_req_ready, mem_resp_valid, mem_resp_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one request/response memory port between the instruction-fetch (IF)
// and load/store (LS) requesters. One transaction is in flight at a time:
//   IDLE - arbitrate, handshake with the granted requester, latch its request
//   REQ  - present the latched request to memory until mem_req_ready
//   RESP - wait for mem_resp_valid, capture data for the owner, back to IDLE
// The owner's *_resp_valid pulses for one cycle after the capture edge.
//
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous, active-high reset
//   bus  - mem_arbiter_if.slave (IF, LS and memory handshakes)
//   busy - a transaction is in flight (state != IDLE)
//
// Configuration macro:
//   MEM_ARB_RR_EN - when defined, ties are broken round-robin using a
//                   last_grant register; otherwise LS always wins a tie.
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

   state_t        state, state_nxt;
   owner_t        owner;
   owner_t        grant;
   logic          any_valid;
   logic          accept;
   logic          resp_fire;

   logic [AW-1:0] req_addr;
   logic          req_wen;
   logic [DW-1:0] req_wdata;
   logic [7:0]    req_wmask;

   logic          if_pulse_q, ls_pulse_q;
   logic [DW-1:0] if_data_q, ls_data_q;

`ifdef MEM_ARB_RR_EN
   owner_t        last_grant;
`endif

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   always_comb begin
      any_valid = bus.if_req_valid | bus.ls_req_valid;
`ifdef MEM_ARB_RR_EN
      if (bus.if_req_valid && bus.ls_req_valid)
         grant = (last_grant == OWN_LS) ? OWN_IF : OWN_LS;
      else
         grant = bus.ls_req_valid ? OWN_LS : OWN_IF;
`else
      grant = bus.ls_req_valid ? OWN_LS : OWN_IF;
`endif
   end

   // ------------------------------------------------------------------
   // FSM: next state and handshake strobes
   // ------------------------------------------------------------------
   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      resp_fire = 1'b0;
      case (state)
         IDLE: begin
            // Gated by rst so the combinational readies read 0 during reset.
            if (any_valid && !rst) begin
               accept    = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus.mem_req_ready)
               state_nxt = RESP;
         end
         RESP: begin
            if (bus.mem_resp_valid) begin
               resp_fire = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ------------------------------------------------------------------
   // Request latch, owner and response registers
   // ------------------------------------------------------------------
   // NOTE: the datapath registers are reset as well, so the memory port and
   // response data read 0 after reset instead of stale or unknown values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_IF;
         req_addr   <= '0;
         req_wen    <= 1'b0;
         req_wdata  <= '0;
         req_wmask  <= '0;
         if_pulse_q <= 1'b0;
         ls_pulse_q <= 1'b0;
         if_data_q  <= '0;
         ls_data_q  <= '0;
      end else begin
         if_pulse_q <= 1'b0;
         ls_pulse_q <= 1'b0;

         if (accept) begin
            owner <= grant;
            if (grant == OWN_LS) begin
               req_addr  <= bus.ls_req_addr;
               req_wen   <= bus.ls_req_wen;
               req_wdata <= bus.ls_req_wdata;
               req_wmask <= bus.ls_req_wmask;
            end else begin
               // Fetches are reads; the write fields are cleared.
               req_addr  <= bus.if_req_addr;
               req_wen   <= 1'b0;
               req_wdata <= '0;
               req_wmask <= '0;
            end
         end

         // Stores also get a pulse; the memory data is passed through as-is.
         if (resp_fire) begin
            if (owner == OWN_LS) begin
               ls_pulse_q <= 1'b1;
               ls_data_q  <= bus.mem_resp_data;
            end else begin
               if_pulse_q <= 1'b1;
               if_data_q  <= bus.mem_resp_data;
            end
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remembers who won the most recent handshake, for tie-breaking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= OWN_IF;
      else if (accept)
         last_grant <= grant;
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.if_req_ready  = accept && (grant == OWN_IF);
   assign bus.ls_req_ready  = accept && (grant == OWN_LS);

   assign bus.if_resp_valid = if_pulse_q;
   assign bus.if_resp_data  = if_data_q;
   assign bus.ls_resp_valid = ls_pulse_q;
   assign bus.ls_resp_data  = ls_data_q;

   // Decodes of the state register only; async reset clears them at once.
   assign bus.mem_req_valid = (state == REQ);
   assign bus.mem_req_addr  = req_addr;
   assign bus.mem_req_wen   = req_wen;
   assign bus.mem_req_wdata = req_wdata;
   assign bus.mem_req_wmask = req_wmask;

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Randomized and directed stimulus for mem_arbiter. A transaction-level model
// tracks which requester should be granted and which phase the single
// outstanding transaction is in; expected responses go into a scoreboard
// queue that a separate monitor drains whenever a *_resp_valid pulse shows up.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 64;
   localparam int DW = 64;

   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} own_e;
   typedef enum int {PH_FREE, PH_REQ, PH_RESP} phase_e;
   typedef struct { own_e owner; logic [DW-1:0] data; int due; } resp_t;
   typedef struct { logic [AW-1:0] addr; logic wen; logic [DW-1:0] wdata; logic [7:0] wmask; } req_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard / model state
   resp_t  sb[$];
   own_e   grant_log[$];
   bit     log_en = 1'b0;
   phase_e m_phase = PH_FREE;
   own_e   m_owner = OWN_IF;
   own_e   m_last  = OWN_IF;
   req_t   m_req;
   int     n_checks = 0;
   int     n_fail   = 0;

   // Random stimulus knobs (percent)
   int p_if = 50, p_ls = 50, p_mrdy = 60, p_mresp = 50;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Grant rule: lone requester wins; on a tie LS wins (fixed) or the one
   // that did not win last time (round-robin).
   function automatic own_e pick(input logic ivld, input logic lvld);
      if (ivld && lvld) begin
`ifdef MEM_ARB_RR_EN
         return (m_last == OWN_LS) ? OWN_IF : OWN_LS;
`else
         return OWN_LS;
`endif
      end
      return lvld ? OWN_LS : OWN_IF;
   endfunction

   task automatic drive_rand();
      bus.if_req_valid   = ($urandom_range(99) < p_if);
      bus.if_req_addr    = {$urandom, $urandom};
      bus.ls_req_valid   = ($urandom_range(99) < p_ls);
      bus.ls_req_addr    = {$urandom, $urandom};
      bus.ls_req_wen     = 1'($urandom_range(1));
      bus.ls_req_wdata   = {$urandom, $urandom};
      bus.ls_req_wmask   = 8'($urandom);
      bus.mem_req_ready  = ($urandom_range(99) < p_mrdy);
      bus.mem_resp_valid = ($urandom_range(99) < p_mresp);
      bus.mem_resp_data  = {$urandom, $urandom};
   endtask

   // One clock: check at negedge, predict the edge, advance the model at
   // posedge + 1. Must be entered at posedge + 1 with inputs already driven.
   task automatic step();
      own_e g;
      bit   acc, mhs, cap;
      @(negedge clk);
      acc = (m_phase == PH_FREE) && (bus.if_req_valid || bus.ls_req_valid);
      g   = pick(bus.if_req_valid, bus.ls_req_valid);
      check("if_req_ready", bus.if_req_ready, acc && g == OWN_IF);
      check("ls_req_ready", bus.ls_req_ready, acc && g == OWN_LS);
      check("busy", busy, m_phase != PH_FREE);
      check("mem_req_valid", bus.mem_req_valid, m_phase == PH_REQ);
      if (m_phase == PH_REQ) begin
         check("mem_req_addr",  bus.mem_req_addr,  m_req.addr);
         check("mem_req_wen",   bus.mem_req_wen,   m_req.wen);
         check("mem_req_wdata", bus.mem_req_wdata, m_req.wdata);
         check("mem_req_wmask", bus.mem_req_wmask, m_req.wmask);
      end
      if (log_en && (bus.if_req_ready || bus.ls_req_ready))
         grant_log.push_back(bus.ls_req_ready ? OWN_LS : OWN_IF);
      mhs = (m_phase == PH_REQ) && bus.mem_req_ready;
      cap = (m_phase == PH_RESP) && bus.mem_resp_valid;
      if (cap)
         sb.push_back('{owner: m_owner, data: bus.mem_resp_data, due: cyc + 1});
      if (acc) begin
         if (g == OWN_LS)
            m_req = '{addr: bus.ls_req_addr, wen: bus.ls_req_wen,
                      wdata: bus.ls_req_wdata, wmask: bus.ls_req_wmask};
         else
            m_req = '{addr: bus.if_req_addr, wen: 1'b0, wdata: '0, wmask: '0};
      end
      @(posedge clk);
      #1;
      if (acc) begin
         m_phase = PH_REQ;
         m_owner = g;
         m_last  = g;
      end else if (mhs) begin
         m_phase = PH_RESP;
      end else if (cap) begin
         m_phase = PH_FREE;
      end
   endtask

   task automatic drain();
      bus.if_req_valid   = 1'b0;
      bus.ls_req_valid   = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      for (int i = 0; i < 10 && m_phase != PH_FREE; i++) step();
      bus.mem_resp_valid = 1'b0;
      step();
      step();
      check("drain_busy", busy, 1'b0);
   endtask

   // Response monitor: every pulse must match the head of the scoreboard,
   // arrive on the predicted cycle and be the only pulse this cycle.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         if (bus.if_resp_valid || bus.ls_resp_valid) begin
            check("resp_pulse_count", 64'(bus.if_resp_valid) + 64'(bus.ls_resp_valid), 1);
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got if=%0b ls=%0b expected none (cycle %0d)",
                        bus.if_resp_valid, bus.ls_resp_valid, cyc);
            end else begin
               e = sb.pop_front();
               check("resp_owner_ls", bus.ls_resp_valid, e.owner == OWN_LS);
               check("resp_data", bus.ls_resp_valid ? bus.ls_resp_data : bus.if_resp_data, e.data);
               check("resp_cycle", cyc, e.due);
            end
         end
      end
   end

   // Hard stop in case something blocks forever.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      own_e last0;

      // ---------------- reset state ----------------
      bus.if_req_valid   = 1'b1;
      bus.if_req_addr    = 64'h1234;
      bus.ls_req_valid   = 1'b1;
      bus.ls_req_addr    = 64'h5678;
      bus.ls_req_wen     = 1'b1;
      bus.ls_req_wdata   = 64'hFFFF;
      bus.ls_req_wmask   = 8'hFF;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 64'hABCD;
      #3;
      check("rst_if_req_ready", bus.if_req_ready, 1'b0);
      check("rst_ls_req_ready", bus.ls_req_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
      check("rst_ls_resp_valid", bus.ls_resp_valid, 1'b0);
      check("rst_mem_req_addr", bus.mem_req_addr, '0);
      check("rst_mem_req_wdata", bus.mem_req_wdata, '0);
      check("rst_mem_req_wmask", bus.mem_req_wmask, '0);
      check("rst_if_resp_data", bus.if_resp_data, '0);
      check("rst_ls_resp_data", bus.ls_resp_data, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.if_req_valid   = 1'b0;
      bus.ls_req_valid   = 1'b0;
      bus.mem_resp_valid = 1'b0;
      @(posedge clk);
      #1;

      // ---------------- single IF fetch, memory ready at once ----------------
      bus.if_req_valid   = 1'b1;
      bus.if_req_addr    = 64'h8000_0000;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 64'h0010_0073;
      step();                       // cycle 0: accept
      bus.if_req_valid = 1'b0;
      step();                       // cycle 1: REQ
      step();                       // cycle 2: RESP, capture
      bus.mem_resp_valid = 1'b0;
      step();                       // cycle 3: pulse
      step();

      // ---------------- LS store with a 3-cycle memory stall ----------------
      bus.ls_req_valid  = 1'b1;
      bus.ls_req_addr   = 64'h8000_1000;
      bus.ls_req_wen    = 1'b1;
      bus.ls_req_wdata  = 64'hDEAD_BEEF;
      bus.ls_req_wmask  = 8'hFF;
      bus.mem_req_ready = 1'b0;
      step();                       // accept
      bus.ls_req_valid  = 1'b0;
      bus.ls_req_addr   = 64'h0;    // must not disturb the latched request
      bus.ls_req_wdata  = 64'h0;
      bus.mem_resp_valid = 1'b1;    // spurious while in REQ
      bus.mem_resp_data  = 64'h5555_AAAA;
      repeat (3) step();            // stalled in REQ
      bus.mem_req_ready  = 1'b1;
      step();                       // REQ -> RESP
      bus.mem_resp_data  = 64'h0000_0000_CAFE_F00D;
      step();                       // capture
      bus.mem_resp_valid = 1'b0;
      step();
      step();

      // ---------------- spurious response while idle ----------------
      bus.mem_resp_valid = 1'b1;
      repeat (3) step();
      bus.mem_resp_valid = 1'b0;

      // ---------------- both requesters valid, back-to-back ----------------
      last0   = m_last;
      log_en  = 1'b1;
      grant_log.delete();
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b1;
      repeat (13) begin
         bus.if_req_valid  = 1'b1;
         bus.if_req_addr   = {$urandom, $urandom};
         bus.ls_req_valid  = 1'b1;
         bus.ls_req_addr   = {$urandom, $urandom};
         bus.ls_req_wen    = 1'b0;
         bus.mem_resp_data = {$urandom, $urandom};
         step();
      end
      log_en = 1'b0;
      check("tie_grant_count_ge4", grant_log.size() >= 4, 1'b1);
      for (int k = 0; k < grant_log.size(); k++) begin
`ifdef MEM_ARB_RR_EN
         check("tie_rr_alternate", grant_log[k], (k == 0) ? ~last0 : ~grant_log[k-1]);
`else
         check("tie_fixed_ls", grant_log[k], OWN_LS);
`endif
      end
      drain();

      // ---------------- async reset in the middle of RESP ----------------
      bus.if_req_valid   = 1'b1;
      bus.if_req_addr    = 64'h8000_2000;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      step();                       // accept
      bus.if_req_valid = 1'b0;
      step();                       // REQ -> RESP
      @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      bus.mem_resp_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      check("async_rst_if_resp_data", bus.if_resp_data, '0);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      bus.mem_resp_valid = 1'b0;
      m_phase = PH_FREE;
      m_last  = OWN_IF;
      @(posedge clk);
      #1;
      check("post_rst_busy", busy, 1'b0);

      // next request after reset completes normally
      bus.ls_req_valid   = 1'b1;
      bus.ls_req_addr    = 64'h8000_3008;
      bus.ls_req_wen     = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 64'h0123_4567_89AB_CDEF;
      step();
      bus.ls_req_valid = 1'b0;
      drain();

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 1500; i++) begin
         drive_rand();
         step();
      end
      drain();

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
